adc_frame_capture: RTL
======================

# adc_frame_capture

Samples a parallel ADC on the 65.536 MHz system clock using an internal clock-enable divider, stores one frame of samples in on-chip RAM, then streams the frame downstream over a valid/ready interface with a last-beat marker. It sits directly downstream of the clock-division stage. It drives the ADC sample clock pin with a divided clock (6.5536 MHz by default) and feeds the spectrum/analysis stage. Capture is one-shot per `start` request.

## Interface
- `CLK_DIV`, default 10: system clocks per sample period; must be even and ≥4 (10 gives 6.5536 MHz).
- `DATA_W`, default 12: ADC sample width.
- `FRAME_LEN`, default 1024: samples per frame; must be a power of two.
- `ADDR_W`, default 10: log2(FRAME_LEN).

Ports:
- `clk_65_536m`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: capture request; sampled only in IDLE.
- `adc_data`, in, DATA_W: ADC output, offset binary.
- `adc_clk`, out, 1: registered ADC sample clock, 50 % duty.
- `busy`, out, 1: high in CAPTURE and DRAIN.
- `done`, out, 1: one-cycle pulse after the last beat is accepted.
- `m_tdata`, out, DATA_W: sample in two's complement.
- `m_tvalid`, out, 1: output beat valid.
- `m_tready`, in, 1: downstream accept.
- `m_tlast`, out, 1: high on beat FRAME_LEN-1.

## Operation
- Divider `div_cnt` runs free over 0..CLK_DIV-1 from reset in every state.
- `adc_clk` is high while `div_cnt` is in 0..CLK_DIV/2-1, low otherwise. It is registered with no glitches.
- Sample strobe `smp_en` fires on the cycle `div_cnt == CLK_DIV/2`, which is the first low cycle of `adc_clk`.
- Conversion: stored word = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]}. Examples: 0x800 → 0x000, 0x000 → 0x800, 0xFFF → 0x7FF.
- FSM states:
  - IDLE → CAPTURE when `start` is high. `wr_addr` clears to 0.
  - CAPTURE: on each `smp_en`, write to mem[wr_addr] and increment `wr_addr`. The write at address FRAME_LEN-1 moves to DRAIN.
  - DRAIN: read mem[0..FRAME_LEN-1] in order onto the stream. When the beat with `m_tlast` is accepted, pulse `done` and go to IDLE.
- `start` is ignored outside IDLE. A held `start` re-triggers on the cycle after returning to IDLE.
- ADC samples arriving during DRAIN and IDLE are discarded.
- Stream rules:
  - Once `m_tvalid` rises it stays high until `m_tvalid && m_tready`.
  - `m_tdata` and `m_tlast` are stable while stalled.
  - No bubbles while `m_tready` is held high. This needs a RAM-read prefetch plus a one-entry skid register.
- Reset (any state, mid-frame included): return to IDLE. `wr_addr`, `rd_addr` and `div_cnt` clear to 0. RAM contents are not cleared.
- Reset values: `adc_clk`=0, `busy`=0, `done`=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0.

## Timing
- First RAM write occurs 1..CLK_DIV cycles after `start` is sampled.
- Capture lasts exactly FRAME_LEN×CLK_DIV cycles minus the phase offset.
- `m_tvalid` first asserts ≤2 cycles after entering DRAIN.
- With `m_tready` held at 1, the drain takes FRAME_LEN consecutive beats.
- `done` pulses the cycle after the final handshake; `busy` falls in that same cycle.
- RAM read latency is 1 cycle. Write and read never overlap because the states are exclusive.

## Structure
- Package `adc_cap_pkg`: state enum (IDLE, CAPTURE, DRAIN) and default constants CLK_DIV, DATA_W, FRAME_LEN.
- Sub-module `sdp_ram`: simple dual-port, inferred block RAM, one write port and one registered read port, parameterised by DATA_W and ADDR_W.
- Divider, FSM, and prefetch/skid logic live in the top module.

## Test plan
- Reset release, idle 100 cycles:
  - `adc_clk` toggles with period 10 and 5 high / 5 low.
  - `busy`=0 and `m_tvalid`=0 throughout.
- Ramp test:
  - Stimulus: `adc_data` increments by 1 per sample period starting at 0x800, `start` pulsed, `m_tready`=1.
  - Response: 1024 beats with `m_tdata` 0x000, 0x001, …, 0x3FF; `m_tlast` only on beat 1023; `done` 1 cycle after.
- Backpressure:
  - Stimulus: `m_tready` pseudo-random, ~30 % high.
  - Response: identical data sequence, no drops or duplicates, `m_tdata` stable while stalled.
- Conversion:
  - Stimulus: constant `adc_data` of 0xFFF, then 0x000.
  - Response: all beats 0x7FF, then all beats 0x800.
- `start` held high for 3 frames: back-to-back frames, each followed by exactly one `done` pulse; `start` pulses during CAPTURE have no effect.
- Reset asserted mid-CAPTURE at sample 500: outputs return to reset values next cycle; a new `start` yields a full 1024-sample frame starting at address 0.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: capture FSM state encoding and default sizing constants
package adc_cap_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
  localparam int CLK_DIV = 10;
  localparam int DATA_W = 12;
  localparam int FRAME_LEN = 1024;
endpackage

// File: rtl/adc_frame_capture_sdp_ram.sv
// sdp_ram: simple dual-port block RAM, one write port and one registered read port
module sdp_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/adc_frame_capture.sv
// adc_frame_capture: one-shot ADC frame capture into block RAM, streamed out over valid/ready
module adc_frame_capture #(
  parameter int CLK_DIV = adc_cap_pkg::CLK_DIV,
  parameter int DATA_W = adc_cap_pkg::DATA_W,
  parameter int FRAME_LEN = adc_cap_pkg::FRAME_LEN,
  parameter int ADDR_W = $clog2(FRAME_LEN)
) (
  input  logic              clk_65_536m,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_clk,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
);
  import adc_cap_pkg::*;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;
  state_t state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0] rd_addr_q, rd_addr_d;
  logic adc_clk_q, adc_clk_d, done_q, done_d;
  logic rd_pend_q, rd_pend_d, rd_last_q, rd_last_d;
  logic out_v_q, out_v_d, out_last_q, out_last_d;
  logic skid_v_q, skid_v_d, skid_last_q, skid_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d, rd_data;
  logic smp_en, we, re, pop, fin, load_out;

  assign smp_en = div_cnt_q == DIV_W'(HALF);
  assign we = state_q == CAPTURE && smp_en;
  assign pop = out_v_q && m_tready;
  assign fin = pop && out_last_q;
  // A read is only issued if its data is guaranteed a free slot (output or skid) when it lands
  assign re = state_q == DRAIN && rd_addr_q < (ADDR_W+1)'(FRAME_LEN)
              && (2'(out_v_q) + 2'(skid_v_q) + 2'(rd_pend_q) - 2'(pop)) < 2'd2;
  assign load_out = !out_v_q || pop;

  sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk_65_536m),
    .we(we),
    .re(re),
    .waddr(wr_addr_q),
    .raddr(rd_addr_q[ADDR_W-1:0]),
    .wdata({~adc_data[DATA_W-1], adc_data[DATA_W-2:0]}),
    .rdata(rd_data)
  );

  always_ff @(posedge clk_65_536m) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q == IDLE && start ? CAPTURE
            : we && wr_addr_q == ADDR_W'(FRAME_LEN - 1) ? DRAIN
            : state_q == DRAIN && fin ? IDLE
            : state_q;
  end

  always_comb begin
    busy = state_q != IDLE;
  end

  always_comb begin
    div_cnt_d = div_cnt_q == DIV_W'(CLK_DIV - 1) ? '0 : div_cnt_q + 1'b1;
    adc_clk_d = div_cnt_d < DIV_W'(HALF);
    wr_addr_d = state_q == CAPTURE ? wr_addr_q + ADDR_W'(we) : '0;
    rd_addr_d = state_q == DRAIN ? rd_addr_q + (ADDR_W+1)'(re) : '0;
    rd_pend_d = re;
    rd_last_d = rd_addr_q == (ADDR_W+1)'(FRAME_LEN - 1);
    out_v_d = load_out ? skid_v_q || rd_pend_q : 1'b1;
    out_data_d = !load_out ? out_data_q : skid_v_q ? skid_data_q : rd_pend_q ? rd_data : out_data_q;
    out_last_d = !load_out ? out_last_q : skid_v_q ? skid_last_q : rd_pend_q ? rd_last_q : out_last_q;
    skid_v_d = load_out ? skid_v_q && rd_pend_q : skid_v_q || rd_pend_q;
    skid_data_d = rd_pend_q && (!load_out || skid_v_q) ? rd_data : skid_data_q;
    skid_last_d = rd_pend_q && (!load_out || skid_v_q) ? rd_last_q : skid_last_q;
    done_d = fin;
  end

  always_ff @(posedge clk_65_536m) begin
    if (rst) begin
      div_cnt_q <= '0;
      adc_clk_q <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      out_v_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      skid_v_q <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      adc_clk_q <= adc_clk_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_pend_q <= rd_pend_d;
      rd_last_q <= rd_last_d;
      out_v_q <= out_v_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      skid_v_q <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      done_q <= done_d;
    end
  end

  assign adc_clk = adc_clk_q;
  assign done = done_q;
  assign m_tdata = out_data_q;
  assign m_tvalid = out_v_q;
  assign m_tlast = out_last_q;
endmodule
